ysyx_25060166_wbu: RTL and testbench

Writeback unit and register scoreboard on the write side of the RV32E register array.
- Accepts results from EXU and LSU over valid/ready handshakes and arbitrates them.
- Drives the single register-array write port (wen, write_rd, write_data) from a registered stage.
- Tracks in-flight destination registers so IDU can stall on RAW/WAW hazards before reading the array.

---
 rtl/ysyx_25060166_wbu_pkg.sv | 9 +
 rtl/ysyx_25060166_wbu_sb.sv | 45 ++++
 rtl/ysyx_25060166_wbu.sv | 97 +++++++++
 tb/tb_ysyx_25060166_wbu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060166_wbu_pkg.sv
// rtl/ysyx_25060166_wbu_pkg.sv - shared RV32E writeback constants
package ysyx_25060166_wbu_pkg;

    localparam int RV_WIDTH   = 32;
    localparam int RV_REG_NUM = 16;
    localparam int RV_AW      = 5;
    localparam logic [RV_AW-1:0] RV_X0 = '0;

endpackage

// File: rtl/ysyx_25060166_wbu_sb.sv
// rtl/ysyx_25060166_wbu_sb.sv - busy-bit scoreboard with set/clear/query ports
module ysyx_25060166_wbu_sb
    import ysyx_25060166_wbu_pkg::*;
#(
    parameter int REG_NUM = RV_REG_NUM,
    parameter int IDX_W   = $clog2(REG_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [IDX_W-1:0]   set_idx,
    input  logic               clr_en,
    input  logic [IDX_W-1:0]   clr_idx,
    input  logic [IDX_W-1:0]   q0_idx,
    input  logic [IDX_W-1:0]   q1_idx,
    input  logic [IDX_W-1:0]   q2_idx,
    output logic               q0_busy,
    output logic               q1_busy,
    output logic               q2_busy,
    output logic [REG_NUM-1:0] busy
);

    logic [REG_NUM-1:0] busy_nxt;

    // Set is applied after clear; x0 can never become busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_idx] = 1'b0;
        if (set_en && (set_idx != '0))
            busy_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign q0_busy = busy[q0_idx];
    assign q1_busy = busy[q1_idx];
    assign q2_busy = busy[q2_idx];

endmodule

// File: rtl/ysyx_25060166_wbu.sv
// rtl/ysyx_25060166_wbu.sv - writeback arbiter, WB register and RAW/WAW scoreboard
module ysyx_25060166_wbu
    import ysyx_25060166_wbu_pkg::*;
#(
    parameter int WIDTH   = RV_WIDTH,
    parameter int REG_NUM = RV_REG_NUM,
    parameter int AW      = RV_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             exu_valid,
    input  logic [AW-1:0]    exu_rd,
    input  logic [WIDTH-1:0] exu_data,
    output logic             exu_ready,
    input  logic             lsu_valid,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    output logic             lsu_ready,
    output logic             wen,
    output logic [AW-1:0]    write_rd,
    output logic [WIDTH-1:0] write_data
);

    localparam int IDX_W = $clog2(REG_NUM);
    localparam logic [AW-1:0] X0 = AW'(RV_X0);

    logic               acc;
    logic [AW-1:0]      acc_rd;
    logic [WIDTH-1:0]   acc_data;
    logic               issue_q_busy;
    logic               rs1_q_busy;
    logic               rs2_q_busy;
    logic               issue_fire;
    logic [REG_NUM-1:0] busy;

    // LSU always wins; EXU waits while a load result is presented.
    assign lsu_ready = 1'b1;
    assign exu_ready = !lsu_valid;
    assign acc       = lsu_valid || exu_valid;
    assign acc_rd    = lsu_valid ? lsu_rd   : exu_rd;
    assign acc_data  = lsu_valid ? lsu_data : exu_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen        <= 1'b0;
            write_rd   <= '0;
            write_data <= '0;
        end else begin
            wen <= acc && (acc_rd != X0);
            if (acc) begin
                write_rd   <= acc_rd;
                write_data <= acc_data;
            end
        end
    end

    assign issue_ready = !issue_q_busy || (issue_rd == X0);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != X0);
    assign rs1_busy    = rs1_q_busy && (raddr1 != X0);
    assign rs2_busy    = rs2_q_busy && (raddr2 != X0);

    // Busy clears on the edge the array takes the write, never earlier.
    ysyx_25060166_wbu_sb #(
        .REG_NUM (REG_NUM),
        .IDX_W   (IDX_W)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_fire),
        .set_idx (issue_rd[IDX_W-1:0]),
        .clr_en  (wen),
        .clr_idx (write_rd[IDX_W-1:0]),
        .q0_idx  (issue_rd[IDX_W-1:0]),
        .q1_idx  (raddr1[IDX_W-1:0]),
        .q2_idx  (raddr2[IDX_W-1:0]),
        .q0_busy (issue_q_busy),
        .q1_busy (rs1_q_busy),
        .q2_busy (rs2_q_busy),
        .busy    (busy)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && acc && (acc_rd[IDX_W-1:0] != '0))
            assert (busy[acc_rd[IDX_W-1:0]])
            else $error("wbu: result for non-busy rd %0d", acc_rd);
    end
`endif

endmodule

// File: tb/tb_ysyx_25060166_wbu.sv
// tb/tb_ysyx_25060166_wbu.sv - randomized self-checking bench for ysyx_25060166_wbu
module tb_ysyx_25060166_wbu;
    import ysyx_25060166_wbu_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             issue_valid = 1'b0;
    logic [RV_AW-1:0] issue_rd = '0;
    logic             issue_ready;
    logic [RV_AW-1:0] raddr1 = '0;
    logic [RV_AW-1:0] raddr2 = '0;
    logic             rs1_busy, rs2_busy;
    logic             exu_valid = 1'b0;
    logic [RV_AW-1:0] exu_rd = '0;
    logic [31:0]      exu_data = '0;
    logic             exu_ready;
    logic             lsu_valid = 1'b0;
    logic [RV_AW-1:0] lsu_rd = '0;
    logic [31:0]      lsu_data = '0;
    logic             lsu_ready;
    logic             wen;
    logic [RV_AW-1:0] write_rd;
    logic [31:0]      write_data;

    ysyx_25060166_wbu dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .raddr1(raddr1), .raddr2(raddr2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wen(wen), .write_rd(write_rd), .write_data(write_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: which registers await a result, and what the write port must show.
    bit         busy_m[16];
    bit         exp_wen = 1'b0;
    logic [4:0] exp_rd = '0;
    logic [31:0] exp_data = '0;
    int         results_nz = 0;
    int         pulses = 0;
    bit         last_exu_acc = 1'b0;
    bit         last_fire = 1'b0;
    logic [3:0] last_fire_rd = '0;
    logic [3:0] owed[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 5'd0) && busy_m[a[3:0]];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) busy_m[r] = 1'b0;
        exp_wen  = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check the write port.
    task automatic step();
        bit i_rdy, l_acc, e_acc;
        #1;
        i_rdy = (issue_rd == 5'd0) || !busy_m[issue_rd[3:0]];
        chk("issue_ready", issue_ready, i_rdy);
        chk("rs1_busy", rs1_busy, m_busy(raddr1));
        chk("rs2_busy", rs2_busy, m_busy(raddr2));
        chk("lsu_ready", lsu_ready, 1);
        chk("exu_ready", exu_ready, !lsu_valid);
        l_acc = lsu_valid;
        e_acc = exu_valid && !lsu_valid;
        last_fire    = issue_valid && i_rdy && (issue_rd != 5'd0);
        last_fire_rd = issue_rd[3:0];
        last_exu_acc = e_acc;
        if (exp_wen) busy_m[exp_rd[3:0]] = 1'b0;
        if (last_fire) busy_m[last_fire_rd] = 1'b1;
        exp_wen = 1'b0;
        if (l_acc || e_acc) begin
            exp_rd   = l_acc ? lsu_rd : exu_rd;
            exp_data = l_acc ? lsu_data : exu_data;
            exp_wen  = (exp_rd != 5'd0);
            if (exp_wen) results_nz++;
        end
        @(posedge clk);
        #1;
        chk("wen", wen, exp_wen);
        chk("write_rd", write_rd, exp_rd);
        chk("write_data", write_data, exp_data);
        if (wen) pulses++;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        exu_valid   = 1'b0;
        lsu_valid   = 1'b0;
    endtask

    initial begin
        int idx;
        model_reset();
        #12;
        chk("rst_wen", wen, 0);
        chk("rst_write_rd", write_rd, 0);
        chk("rst_write_data", write_data, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // single EXU op
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_valid = 1'b0; raddr1 = 5'd3;
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h12345678;
        step();
        chk("single_wen", wen, 1);
        chk("single_rd", write_rd, 3);
        chk("single_data", write_data, 32'h12345678);
        chk("single_rs1_hold", rs1_busy, 1);
        exu_valid = 1'b0;
        step();
        chk("single_rs1_clear", rs1_busy, 0);
        chk("single_wen_once", wen, 0);

        // LSU/EXU collision
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        issue_rd = 5'd6;
        step();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hAAAA0000;
        exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'h0000BBBB;
        #1 chk("coll_exu_ready", exu_ready, 0);
        step();
        chk("coll_first_rd", write_rd, 4);
        chk("coll_first_data", write_data, 32'hAAAA0000);
        lsu_valid = 1'b0;
        step();
        chk("coll_second_wen", wen, 1);
        chk("coll_second_rd", write_rd, 6);
        chk("coll_second_data", write_data, 32'h0000BBBB);
        idle();
        step();

        // WAW stall on rd=7
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        #1 chk("waw_stall", issue_ready, 0);
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'hC0FFEE07;
        step();
        exu_valid = 1'b0;
        #1 chk("waw_stall_wb", issue_ready, 0);
        step();
        #1 chk("waw_release", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77777777;
        step();
        exu_valid = 1'b0;
        step();

        // x0 handling
        issue_valid = 1'b1; issue_rd = 5'd0; raddr1 = 5'd0;
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hFFFFFFFF;
        #1 chk("x0_issue_ready", issue_ready, 1);
        step();
        chk("x0_wen", wen, 0);
        chk("x0_rs1_busy", rs1_busy, 0);
        idle();
        step();

        // reset with a result on the write port
        issue_valid = 1'b1; issue_rd = 5'd5;
        step();
        issue_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h55AA55AA;
        step();
        exu_valid = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_wen", wen, 0);
        chk("midrst_write_rd", write_rd, 0);
        chk("midrst_write_data", write_data, 0);
        for (int r = 1; r < 16; r++) begin
            raddr1 = 5'(r);
            #1 chk("midrst_busy", rs1_busy, 0);
        end
        @(posedge clk);
        #1 chk("midrst_hold_wen", wen, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("midrst_no_write", wen, 0);

        // random traffic
        pulses = 0;
        results_nz = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!(exu_valid && !last_exu_acc)) begin
                exu_valid = 1'b0;
                if (owed.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, owed.size() - 1);
                    exu_rd = {1'b0, owed[idx]};
                    owed.delete(idx);
                    exu_data = $urandom;
                    exu_valid = 1'b1;
                end
            end
            lsu_valid = 1'b0;
            if (owed.size() > 0 && $urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, owed.size() - 1);
                lsu_rd = {1'b0, owed[idx]};
                owed.delete(idx);
                lsu_data = $urandom;
                lsu_valid = 1'b1;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 15));
            raddr1      = 5'($urandom_range(0, 31));
            raddr2      = 5'($urandom_range(0, 31));
            step();
            if (last_fire) owed.push_back(last_fire_rd);
        end
        idle();
        step();
        chk("wen_pulses", pulses, results_nz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
